// File: rtl/execute_mem_pipe_if.sv
// Issue-to-writeback bus of the memory functional unit.
// The issue side is the master; the memory unit is the slave.
interface execute_mem_pipe_if #(
    parameter int ADDR_W = 7
);
    logic [1:0]        is_m0_functionalunit;
    logic [2:0]        is_m0_aluop;
    logic              is_m0_unsig;
    logic [31:0]       is_m0_rega;
    logic [31:0]       is_m0_imedext;
    logic [31:0]       is_m0_regb;
    logic              is_m0_readmem;
    logic              is_m0_writemem;
    logic [4:0]        is_m0_regdest;
    logic              is_m0_writereg;
    logic [4:0]        m_wb_regdest;
    logic              m_wb_writereg;
    logic [31:0]       m_wb_wbvalue;
    logic              m_wb_excp;
    logic [ADDR_W-1:0] m_wb_badaddr;

    modport master (
        output is_m0_functionalunit, is_m0_aluop, is_m0_unsig, is_m0_rega,
               is_m0_imedext, is_m0_regb, is_m0_readmem, is_m0_writemem,
               is_m0_regdest, is_m0_writereg,
        input  m_wb_regdest, m_wb_writereg, m_wb_wbvalue, m_wb_excp, m_wb_badaddr
    );

    modport slave (
        input  is_m0_functionalunit, is_m0_aluop, is_m0_unsig, is_m0_rega,
               is_m0_imedext, is_m0_regb, is_m0_readmem, is_m0_writemem,
               is_m0_regdest, is_m0_writereg,
        output m_wb_regdest, m_wb_writereg, m_wb_wbvalue, m_wb_excp, m_wb_badaddr
    );
endinterface

// File: rtl/execute_mem_pipe.sv
// Memory functional unit: byte/half/word loads and stores over an internal
// byte-addressed RAM, with misalignment trapping and a configurable-depth pipe.
module execute_mem_pipe #(
    parameter int ADDR_W = 7,
    parameter int STAGES = 4,
    parameter int FU_ID  = 2
) (
    input logic               clock,
    input logic               reset,
    execute_mem_pipe_if.slave bus
);
    localparam int WORDS = 1 << (ADDR_W - 2);

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic unsig);
        logic [31:0]        shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        // Halves are always aligned here, so lane is 0 or 2 for them.
        shifted = word >> {lane, 3'b000};
        b = shifted[7:0];
        h = shifted[15:0];
        if (size[1]) return word;
        if (size[0]) return unsig ? {16'h0000, h} : 32'(h);
        return unsig ? {24'h000000, b} : 32'(b);
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] data,
                                                input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] mask;
        logic [31:0] wdata;
        if (size[1]) begin
            mask  = '1;
            wdata = data;
        end else if (size[0]) begin
            mask  = 32'h0000_FFFF << {lane[1], 4'b0000};
            wdata = {2{data[15:0]}};
        end else begin
            mask  = 32'h0000_00FF << {lane, 3'b000};
            wdata = {4{data[7:0]}};
        end
        return (old & ~mask) | (wdata & mask);
    endfunction

    logic [31:0]       sum;
    logic [ADDR_W-1:0] ea;
    logic [1:0]        size;
    logic              accept;
    logic              misaligned;
    logic              unused_bits;

    assign sum         = bus.is_m0_rega + bus.is_m0_imedext;
    assign ea          = sum[ADDR_W-1:0];
    assign size        = bus.is_m0_aluop[1:0];
    assign accept      = (bus.is_m0_functionalunit == 2'(FU_ID));
    assign misaligned  = (size[1] && ea[1:0] != 2'b00) || (size == 2'b01 && ea[0]);
    assign unused_bits = ^{sum[31:ADDR_W], bus.is_m0_aluop[2]};

    // ---- M0: decoded instruction register ----
    logic [ADDR_W-1:0] ea_p0;
    logic [ADDR_W-1:0] badaddr_p0;
    logic [1:0]        size_p0;
    logic              unsig_p0;
    logic [31:0]       regb_p0;
    logic              readmem_p0;
    logic              writemem_p0;
    logic              writereg_p0;
    logic              excp_p0;
    logic [4:0]        regdest_p0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ea_p0       <= '0;
            badaddr_p0  <= '0;
            size_p0     <= '0;
            unsig_p0    <= 1'b0;
            regb_p0     <= '0;
            readmem_p0  <= 1'b0;
            writemem_p0 <= 1'b0;
            writereg_p0 <= 1'b0;
            excp_p0     <= 1'b0;
            regdest_p0  <= '0;
        end else begin
            ea_p0       <= accept ? ea : '0;
            badaddr_p0  <= (accept && misaligned) ? ea : '0;
            size_p0     <= accept ? size : 2'b00;
            unsig_p0    <= accept & bus.is_m0_unsig;
            regb_p0     <= accept ? bus.is_m0_regb : '0;
            readmem_p0  <= accept & ~misaligned & bus.is_m0_readmem & ~bus.is_m0_writemem;
            writemem_p0 <= accept & ~misaligned & bus.is_m0_writemem;
            writereg_p0 <= accept & ~misaligned & bus.is_m0_writereg;
            excp_p0     <= accept & misaligned;
            regdest_p0  <= accept ? bus.is_m0_regdest : '0;
        end
    end

    // ---- M1: RAM access; the store lands on the same edge that loads M1 ----
    logic [31:0]       mem [WORDS];
    logic [ADDR_W-3:0] word_idx;
    logic [31:0]       rdata;
    logic [31:0]       value_m1;

    assign word_idx = ea_p0[ADDR_W-1:2];
    assign rdata    = mem[word_idx];

    always_comb begin
        value_m1 = {{(32-ADDR_W){1'b0}}, ea_p0};
        if (writemem_p0)
            value_m1 = '0;
        else if (readmem_p0)
            value_m1 = load_extend(rdata, ea_p0[1:0], size_p0, unsig_p0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (writemem_p0) begin
            mem[word_idx] <= store_merge(rdata, regb_p0, ea_p0[1:0], size_p0);
        end
    end

    // ---- M1 .. M(STAGES-1): result register followed by pure delay ----
    logic [4:0]        regdest_pn  [1:STAGES-1];
    logic              writereg_pn [1:STAGES-1];
    logic [31:0]       wbvalue_pn  [1:STAGES-1];
    logic              excp_pn     [1:STAGES-1];
    logic [ADDR_W-1:0] badaddr_pn  [1:STAGES-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 1; s < STAGES; s++) begin
                regdest_pn[s]  <= '0;
                writereg_pn[s] <= 1'b0;
                wbvalue_pn[s]  <= '0;
                excp_pn[s]     <= 1'b0;
                badaddr_pn[s]  <= '0;
            end
        end else begin
            regdest_pn[1]  <= regdest_p0;
            writereg_pn[1] <= writereg_p0;
            wbvalue_pn[1]  <= value_m1;
            excp_pn[1]     <= excp_p0;
            badaddr_pn[1]  <= badaddr_p0;
            for (int s = 2; s < STAGES; s++) begin
                regdest_pn[s]  <= regdest_pn[s-1];
                writereg_pn[s] <= writereg_pn[s-1];
                wbvalue_pn[s]  <= wbvalue_pn[s-1];
                excp_pn[s]     <= excp_pn[s-1];
                badaddr_pn[s]  <= badaddr_pn[s-1];
            end
        end
    end

    assign bus.m_wb_regdest  = regdest_pn[STAGES-1];
    assign bus.m_wb_writereg = writereg_pn[STAGES-1];
    assign bus.m_wb_wbvalue  = wbvalue_pn[STAGES-1];
    assign bus.m_wb_excp     = excp_pn[STAGES-1];
    assign bus.m_wb_badaddr  = badaddr_pn[STAGES-1];
endmodule

// File: tb/tb_execute_mem_pipe.sv
// Directed bench for execute_mem_pipe: identical stimulus drives a 4-stage and
// a 2-stage instance, each checked at its own latency.
module tb_execute_mem_pipe;
    localparam int ADDR_W = 7;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    execute_mem_pipe_if #(.ADDR_W(ADDR_W)) bus4 ();
    execute_mem_pipe_if #(.ADDR_W(ADDR_W)) bus2 ();

    execute_mem_pipe #(.ADDR_W(ADDR_W), .STAGES(4), .FU_ID(2)) dut4 (
        .clock(clock), .reset(reset), .bus(bus4));
    execute_mem_pipe #(.ADDR_W(ADDR_W), .STAGES(2), .FU_ID(2)) dut2 (
        .clock(clock), .reset(reset), .bus(bus2));

    typedef struct {
        logic [1:0]  fu;
        logic [2:0]  aluop;
        logic        unsig;
        logic [31:0] rega;
        logic [31:0] imed;
        logic [31:0] regb;
        logic        rd;
        logic        wm;
        logic [4:0]  rdest;
        logic        wr;
        logic [45:0] expect_out;  // {regdest, writereg, wbvalue, excp, badaddr}
        logic        chk_all;     // 0: regdest/wbvalue not defined for this vector
    } vec_t;

    vec_t vecs [0:23];
    vec_t bubble;

    function automatic vec_t mk(input logic [1:0] fu, input logic [2:0] aluop, input logic unsig,
                                input logic [31:0] rega, input logic [31:0] imed, input logic [31:0] regb,
                                input logic rd, input logic wm, input logic [4:0] rdest, input logic wr,
                                input logic [4:0] e_rdest, input logic e_wr, input logic [31:0] e_val,
                                input logic e_excp, input logic [6:0] e_bad, input logic chk_all);
        vec_t v;
        v.fu = fu; v.aluop = aluop; v.unsig = unsig; v.rega = rega; v.imed = imed; v.regb = regb;
        v.rd = rd; v.wm = wm; v.rdest = rdest; v.wr = wr;
        v.expect_out = {e_rdest, e_wr, e_val, e_excp, e_bad};
        v.chk_all = chk_all;
        return v;
    endfunction

    function automatic logic [45:0] out4();
        return {bus4.m_wb_regdest, bus4.m_wb_writereg, bus4.m_wb_wbvalue, bus4.m_wb_excp, bus4.m_wb_badaddr};
    endfunction

    function automatic logic [45:0] out2();
        return {bus2.m_wb_regdest, bus2.m_wb_writereg, bus2.m_wb_wbvalue, bus2.m_wb_excp, bus2.m_wb_badaddr};
    endfunction

    task automatic check(input string name, input logic [45:0] act_in, input logic [45:0] exp, input logic chk_all);
        logic [45:0] act;
        act = act_in;
        if (!chk_all) begin
            act[45:41] = exp[45:41];
            act[39:8]  = exp[39:8];
        end
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got rd=%0d wr=%0d val=%h excp=%0d bad=%h, expected rd=%0d wr=%0d val=%h excp=%0d bad=%h",
                     name, act_in[45:41], act_in[40], act_in[39:8], act_in[7], act_in[6:0],
                     exp[45:41], exp[40], exp[39:8], exp[7], exp[6:0]);
        end
    endtask

    task automatic drive(input vec_t v);
        bus4.is_m0_functionalunit = v.fu;   bus2.is_m0_functionalunit = v.fu;
        bus4.is_m0_aluop          = v.aluop; bus2.is_m0_aluop          = v.aluop;
        bus4.is_m0_unsig          = v.unsig; bus2.is_m0_unsig          = v.unsig;
        bus4.is_m0_rega           = v.rega;  bus2.is_m0_rega           = v.rega;
        bus4.is_m0_imedext        = v.imed;  bus2.is_m0_imedext        = v.imed;
        bus4.is_m0_regb           = v.regb;  bus2.is_m0_regb           = v.regb;
        bus4.is_m0_readmem        = v.rd;    bus2.is_m0_readmem        = v.rd;
        bus4.is_m0_writemem       = v.wm;    bus2.is_m0_writemem       = v.wm;
        bus4.is_m0_regdest        = v.rdest; bus2.is_m0_regdest        = v.rdest;
        bus4.is_m0_writereg       = v.wr;    bus2.is_m0_writereg       = v.wr;
    endtask

    // Back-to-back issue of vecs[lo..hi], then bubbles until both pipes drain.
    task automatic run_vecs(input int lo, input int hi);
        int n;
        n = hi - lo + 1;
        for (int i = 0; i < n + 3; i++) begin
            if (i < n) drive(vecs[lo + i]);
            else       drive(bubble);
            @(posedge clock);
            #1;
            if (i >= 1 && i - 1 < n)
                check($sformatf("v%0d_s2", lo + i - 1), out2(), vecs[lo + i - 1].expect_out, vecs[lo + i - 1].chk_all);
            else
                check($sformatf("idle_s2_%0d", lo + i), out2(), 46'h0, 1'b1);
            if (i >= 3)
                check($sformatf("v%0d_s4", lo + i - 3), out4(), vecs[lo + i - 3].expect_out, vecs[lo + i - 3].chk_all);
            else
                check($sformatf("idle_s4_%0d", lo + i), out4(), 46'h0, 1'b1);
        end
    endtask

    initial begin
        vec_t ra, rb, rc, rst_store;
        //               fu     aluop   u     rega           imed      regb           rd    wm    rdest  wr    e_rd   e_wr  e_val          exc   bad    all
        bubble   = mk(2'd0, 3'b000, 1'b0, 32'h0,         32'h0,    32'h0,         1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 32'h0,         1'b0, 7'h00, 1'b1);
        vecs[0]  = mk(2'd2, 3'b010, 1'b0, 32'h10,        32'h4,    32'hDEADBEEF,  1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 32'h0,         1'b0, 7'h00, 1'b1);
        vecs[1]  = mk(2'd2, 3'b010, 1'b0, 32'h14,        32'h0,    32'h0,         1'b1, 1'b0, 5'd5,  1'b1, 5'd5,  1'b1, 32'hDEADBEEF,  1'b0, 7'h00, 1'b1);
        vecs[2]  = mk(2'd2, 3'b000, 1'b0, 32'h10,        32'h7,    32'h0,         1'b1, 1'b0, 5'd6,  1'b1, 5'd6,  1'b1, 32'hFFFFFFDE,  1'b0, 7'h00, 1'b1);
        vecs[3]  = mk(2'd2, 3'b000, 1'b1, 32'h10,        32'h7,    32'h0,         1'b1, 1'b0, 5'd7,  1'b1, 5'd7,  1'b1, 32'h000000DE,  1'b0, 7'h00, 1'b1);
        vecs[4]  = mk(2'd2, 3'b001, 1'b0, 32'h14,        32'h0,    32'h0,         1'b1, 1'b0, 5'd8,  1'b1, 5'd8,  1'b1, 32'hFFFFBEEF,  1'b0, 7'h00, 1'b1);
        vecs[5]  = mk(2'd2, 3'b000, 1'b0, 32'h15,        32'h0,    32'h12345655,  1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 32'h0,         1'b0, 7'h00, 1'b1);
        vecs[6]  = mk(2'd2, 3'b010, 1'b0, 32'h14,        32'h0,    32'h0,         1'b1, 1'b0, 5'd9,  1'b1, 5'd9,  1'b1, 32'hDEAD55EF,  1'b0, 7'h00, 1'b1);
        vecs[7]  = mk(2'd1, 3'b010, 1'b0, 32'h14,        32'h0,    32'h0,         1'b1, 1'b0, 5'd3,  1'b1, 5'd0,  1'b0, 32'h0,         1'b0, 7'h00, 1'b1);
        vecs[8]  = mk(2'd2, 3'b101, 1'b1, 32'h16,        32'h0,    32'h0,         1'b1, 1'b0, 5'd10, 1'b1, 5'd10, 1'b1, 32'h0000DEAD,  1'b0, 7'h00, 1'b1);
        vecs[9]  = mk(2'd2, 3'b010, 1'b0, 32'h10,        32'h3,    32'h0,         1'b1, 1'b0, 5'd11, 1'b1, 5'd11, 1'b0, 32'h0,         1'b1, 7'h13, 1'b0);
        vecs[10] = mk(2'd2, 3'b010, 1'b0, 32'h16,        32'h0,    32'hFFFFFFFF,  1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 32'h0,         1'b1, 7'h16, 1'b0);
        vecs[11] = mk(2'd2, 3'b001, 1'b0, 32'h15,        32'h0,    32'hFFFFFFFF,  1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 32'h0,         1'b1, 7'h15, 1'b0);
        vecs[12] = mk(2'd2, 3'b010, 1'b0, 32'h14,        32'h0,    32'h0,         1'b1, 1'b0, 5'd12, 1'b1, 5'd12, 1'b1, 32'hDEAD55EF,  1'b0, 7'h00, 1'b1);
        vecs[13] = mk(2'd2, 3'b010, 1'b0, 32'hFFFFFFFF,  32'h81,   32'h0,         1'b0, 1'b0, 5'd13, 1'b1, 5'd13, 1'b1, 32'h0,         1'b0, 7'h00, 1'b1);
        vecs[14] = mk(2'd2, 3'b000, 1'b0, 32'h7E,        32'h1,    32'h0,         1'b0, 1'b0, 5'd14, 1'b1, 5'd14, 1'b1, 32'h0000007F,  1'b0, 7'h00, 1'b1);
        vecs[15] = mk(2'd2, 3'b001, 1'b0, 32'h7E,        32'h0,    32'h0000A5B6,  1'b0, 1'b1, 5'd15, 1'b1, 5'd15, 1'b1, 32'h0,         1'b0, 7'h00, 1'b1);
        vecs[16] = mk(2'd2, 3'b010, 1'b0, 32'h7C,        32'h0,    32'h0,         1'b1, 1'b0, 5'd16, 1'b1, 5'd16, 1'b1, 32'hA5B60000,  1'b0, 7'h00, 1'b1);
        vecs[17] = mk(2'd2, 3'b000, 1'b0, 32'h7C,        32'h0,    32'h00000011,  1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 32'h0,         1'b0, 7'h00, 1'b1);
        vecs[18] = mk(2'd2, 3'b010, 1'b0, 32'h7C,        32'h0,    32'h0,         1'b1, 1'b0, 5'd17, 1'b1, 5'd17, 1'b1, 32'hA5B60011,  1'b0, 7'h00, 1'b1);
        vecs[19] = mk(2'd2, 3'b001, 1'b0, 32'h7F,        32'h0,    32'h0,         1'b1, 1'b0, 5'd18, 1'b1, 5'd18, 1'b0, 32'h0,         1'b1, 7'h7F, 1'b0);
        vecs[20] = mk(2'd3, 3'b010, 1'b0, 32'h14,        32'h0,    32'h0,         1'b1, 1'b0, 5'd19, 1'b1, 5'd0,  1'b0, 32'h0,         1'b0, 7'h00, 1'b1);
        // Loads after the mid-stream reset: RAM must read back as zero.
        vecs[21] = mk(2'd2, 3'b010, 1'b0, 32'h20,        32'h0,    32'h0,         1'b1, 1'b0, 5'd1,  1'b1, 5'd1,  1'b1, 32'h0,         1'b0, 7'h00, 1'b1);
        vecs[22] = mk(2'd2, 3'b010, 1'b0, 32'h14,        32'h0,    32'h0,         1'b1, 1'b0, 5'd2,  1'b1, 5'd2,  1'b1, 32'h0,         1'b0, 7'h00, 1'b1);
        vecs[23] = mk(2'd2, 3'b000, 1'b1, 32'h7C,        32'h0,    32'h0,         1'b1, 1'b0, 5'd3,  1'b1, 5'd3,  1'b1, 32'h0,         1'b0, 7'h00, 1'b1);
        ra        = mk(2'd2, 3'b000, 1'b0, 32'h33,        32'h0,    32'h0,         1'b0, 1'b0, 5'd3,  1'b1, 5'd3,  1'b1, 32'h00000033,  1'b0, 7'h00, 1'b1);
        rb        = mk(2'd2, 3'b000, 1'b0, 32'h40,        32'h2,    32'h0,         1'b0, 1'b0, 5'd4,  1'b1, 5'd4,  1'b1, 32'h00000042,  1'b0, 7'h00, 1'b1);
        rc        = mk(2'd2, 3'b000, 1'b0, 32'h11,        32'h11,   32'h0,         1'b0, 1'b0, 5'd6,  1'b1, 5'd6,  1'b1, 32'h00000022,  1'b0, 7'h00, 1'b1);
        rst_store = mk(2'd2, 3'b010, 1'b0, 32'h20,        32'h0,    32'h12345678,  1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 32'h0,         1'b0, 7'h00, 1'b1);

        // Power-on reset.
        drive(bubble);
        repeat (2) @(posedge clock);
        #1;
        check("por_s4", out4(), 46'h0, 1'b1);
        check("por_s2", out2(), 46'h0, 1'b1);
        reset = 1'b1;

        run_vecs(0, 20);

        // Reset while three address ops are in flight and a store sits in M0.
        drive(ra); @(posedge clock); #1;
        drive(rb); @(posedge clock); #1;
        drive(rc); @(posedge clock); #1;
        drive(rst_store); @(posedge clock); #1;
        check("pre_rst_s4", out4(), ra.expect_out, 1'b1);
        check("pre_rst_s2", out2(), rc.expect_out, 1'b1);
        drive(bubble);
        reset = 1'b0;
        #1;
        check("async_rst_s4", out4(), 46'h0, 1'b1);
        check("async_rst_s2", out2(), 46'h0, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        check("in_rst_s4", out4(), 46'h0, 1'b1);
        check("in_rst_s2", out2(), 46'h0, 1'b1);
        reset = 1'b1;

        run_vecs(21, 23);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/execute_mem_pipe.md
# execute_mem_pipe

Parametrised memory functional unit for the issue/execute back end. Replaces the fixed four-stage word-only memory lane with a pipeline of configurable depth over an internal byte-addressed data RAM. Adds byte, half and word accesses with sign or zero extension, misalignment trapping and address wrap. Sits between the issue stage, which it shares with the other functional units, and writeback.

## Interface
- `ADDR_W`, default 7: byte-address width; RAM holds 2^ADDR_W bytes as 2^(ADDR_W-2) 32-bit words.
- `STAGES`, default 4: pipeline registers from issue to writeback; minimum 2 (M0, M1); stages beyond M1 are pure delay.
- `FU_ID`, default 2: functional-unit code this block accepts.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `is_m0_functionalunit` input 2: instruction accepted only when equal to `FU_ID`.
- `is_m0_aluop` input 3: bits [1:0] select access size: 00 byte, 01 half, 1x word. Bit 2 is ignored.
- `is_m0_unsig` input 1: on loads, 1 zero-extends and 0 sign-extends.
- `is_m0_rega` input 32: base.
- `is_m0_imedext` input 32: offset.
- `is_m0_regb` input 32: store data.
- `is_m0_readmem` input 1: load.
- `is_m0_writemem` input 1: store; has priority over `readmem`.
- `is_m0_regdest` input 5: destination register.
- `is_m0_writereg` input 1: register write request.
- `m_wb_regdest` output 5: destination to writeback.
- `m_wb_writereg` output 1: register write enable.
- `m_wb_wbvalue` output 32: value to write back.
- `m_wb_excp` output 1: misaligned-access exception, one-cycle pulse per faulting instruction.
- `m_wb_badaddr` output ADDR_W: faulting effective address; 0 unless `m_wb_excp` is 1.

## Operation
- **Accept.** `is_m0_functionalunit == FU_ID` means accept. Otherwise M0 loads a bubble: every field is 0, including `writereg`, `readmem`, `writemem` and `excp`.
- **M0.** Computes `ea = (is_m0_rega + is_m0_imedext)[ADDR_W-1:0]`. Higher bits are discarded, so the address wraps modulo 2^ADDR_W.
- **Misalignment.** Half access with `ea[0]=1`, or word access with `ea[1:0]!=0`, marks the instruction faulting:
  - readmem, writemem and writereg are forced to 0;
  - excp=1 and badaddr=ea.
  - Applies to loads, stores and plain address ops alike.
- **M1 store.** The RAM write happens at the clock edge that loads the M1 register. Bytes are little-endian within the word at index `ea[ADDR_W-1:2]`:
  - byte: lane `ea[1:0]` gets `regb[7:0]`;
  - half: lanes `{ea[1],0}` and `{ea[1],1}` get `regb[15:0]`;
  - word: all lanes get `regb`.
  - Other lanes are unchanged.
- **M1 load.** Reads the RAM combinationally at word `ea[ADDR_W-1:2]`, extracts the byte or half at the lane offset, and extends per `unsig`. The result is registered into M1 as wbvalue.
- **Non-memory op.** For an accepted op with neither readmem nor writemem, wbvalue is `ea` zero-extended to 32 bits.
- **Store wbvalue.** On a store, wbvalue is 0 and writereg passes through unchanged.
- **Delay stages.** Stages M2 through M(STAGES-1) copy regdest, writereg, wbvalue, excp and badaddr unchanged. No stall input exists; every stage advances every cycle.
- **Reset (asserted low).** Asynchronously clears:
  - all pipeline registers;
  - all outputs to 0;
  - every RAM byte to 0.
- **Reset mid-operation.** Any instruction in flight is dropped. A store in M0 at reset is never written.

## Timing
- **Latency.** An instruction sampled at edge e appears on `m_wb_*` after edge e+STAGES-1. It is held for one cycle and replaced by the next instruction or a bubble.
- **Throughput.** One instruction per cycle.
- **Store visibility.** The RAM write happens at edge e+1.
- **Store then load.** A load sampled at edge e+1 to the same word observes the new data, because its M1 read occurs after the store's write edge. No forwarding logic is needed or allowed beyond this ordering.
- **Same-cycle read/write.** Only one instruction occupies M1, so no simultaneous RAM read and write from different instructions is possible.
- **Bubbles.** A bubble reaches the outputs as all zeros after the same latency.
- **Minimum depth.** With `STAGES=2`, the outputs are the M1 register directly.

## Test plan
- **Reset.** Assert reset mid-stream with a store in M0, then release. Require all outputs 0, a read of any address returns 0, and the in-flight store has no effect.
- **Word round trip, STAGES=4.** Store word rega=0x10, imedext=4, regb=0xDEADBEEF. Load word from ea 0x14 on the next cycle with regdest=5. Require after 3 edges: regdest=5, writereg=1, wbvalue=0xDEADBEEF.
- **Byte/half extension.** After the word store above, perform:
  - load byte ea 0x17, signed → 0xFFFFFFDE;
  - same, unsigned → 0x000000DE;
  - load half ea 0x14, signed → 0xFFFFBEEF.
  - Then store byte 0x55 to ea 0x15. A word load of 0x14 returns 0xDEAD55EF.
- **Misalignment.** Load word at ea 0x13 with writereg=1. Require writereg=0, excp=1 pulse, badaddr=0x13, and the RAM unchanged.
- **Wrap and address op.** rega=0xFFFFFFFF, imedext=0x81, ADDR_W=7, non-memory op with writereg=1. Require wbvalue=0x00000000.
- **Foreign unit and depth.** Send functionalunit=1 between two loads. Require a zero output cycle between them. Repeat the load tests with STAGES=2, latency 1 edge.
